// File: rtl/sync_sram.sv
// Single-port synchronous SRAM for the basic-computer datapath.
// Write-first on we_n=0, one-cycle registered read; rst clears only data_out.
module sync_sram #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_n,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Power-up contents are zero; rst deliberately leaves the array untouched.
  logic [DATA_WIDTH-1:0] mem_r [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] data_out_r;
  logic [DATA_WIDTH-1:0] rd_data_s;
  logic                  wr_en_s;
  logic [DATA_WIDTH-1:0] data_out_nxt_s;

  // Write qualification: reset suppresses any write regardless of we_n.
  always_comb begin
    wr_en_s = 1'b0;
    if (rst) begin
      wr_en_s = 1'b0;
    end else begin
      wr_en_s = ~we_n;
    end
  end

  assign rd_data_s = mem_r[addr];

  // Next output word: write-through on a write cycle, array contents otherwise.
  always_comb begin
    data_out_nxt_s = '0;
    if (wr_en_s) begin
      data_out_nxt_s = data_in;
    end else begin
      data_out_nxt_s = rd_data_s;
    end
  end

  // Array write port, kept separate so the tool infers a block RAM.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[addr] <= data_in;
    end
  end

  // Output register with synchronous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_r <= '0;
    end else begin
      data_out_r <= data_out_nxt_s;
    end
  end

  assign data_out = data_out_r;

endmodule

// File: tb/tb_sync_sram.sv
// Directed self-checking bench for sync_sram: reset, write-through, reads,
// boundary addresses, overwrite/hold and reset mid-operation.
module tb_sync_sram;

  logic        clk;
  logic        rst;
  logic        we_n;
  logic [15:0] addr;
  logic [15:0] data_in;
  logic [15:0] data_out;

  int checks = 0;
  int errors = 0;

  sync_sram #(.ADDR_WIDTH(16), .DATA_WIDTH(16)) dut (
    .clk      (clk),
    .rst      (rst),
    .we_n     (we_n),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive inputs on the falling edge, then move to just after the next rising edge.
  task automatic step(input logic r, input logic w_n, input logic [15:0] a,
                      input logic [15:0] d);
    @(negedge clk);
    rst     = r;
    we_n    = w_n;
    addr    = a;
    data_in = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] expected);
    checks++;
    assert (data_out === expected) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, data_out, expected);
    end
  endtask

  initial begin
    rst     = 1'b1;
    we_n    = 1'b0;
    addr    = 16'h0003;
    data_in = 16'hBEEF;

    step(1'b1, 1'b0, 16'h0003, 16'hBEEF);
    step(1'b1, 1'b0, 16'h0003, 16'hBEEF);
    check("reset_out", 16'h0000);
    step(1'b0, 1'b1, 16'h0003, 16'h0000);
    check("reset_no_write", 16'h0000);

    step(1'b0, 1'b0, 16'h0000, 16'h0000);
    check("wr0_thru", 16'h0000);
    step(1'b0, 1'b0, 16'h0001, 16'h0005);
    check("wr1_thru", 16'h0005);
    step(1'b0, 1'b0, 16'h0002, 16'h000C);
    check("wr2_thru", 16'h000C);
    step(1'b0, 1'b1, 16'h0000, 16'h0000);
    check("rd0", 16'h0000);
    step(1'b0, 1'b1, 16'h0001, 16'h0000);
    check("rd1", 16'h0005);
    step(1'b0, 1'b1, 16'h0002, 16'h0000);
    check("rd2", 16'h000C);

    step(1'b0, 1'b0, 16'h0010, 16'hA5A5);
    check("wr10_thru", 16'hA5A5);
    step(1'b0, 1'b1, 16'h0010, 16'h0000);
    check("rd10", 16'hA5A5);

    step(1'b0, 1'b1, 16'hFFFF, 16'h0000);
    check("rd_top_unwritten", 16'h0000);
    step(1'b0, 1'b0, 16'hFFFF, 16'h1234);
    check("wr_top_thru", 16'h1234);
    step(1'b0, 1'b0, 16'h0000, 16'h4321);
    check("wr_bot_thru", 16'h4321);
    step(1'b0, 1'b1, 16'hFFFF, 16'h0000);
    check("rd_top", 16'h1234);
    step(1'b0, 1'b1, 16'h0000, 16'h0000);
    check("rd_bot", 16'h4321);

    step(1'b0, 1'b0, 16'h0020, 16'h1111);
    check("wr20a_thru", 16'h1111);
    step(1'b0, 1'b0, 16'h0020, 16'h2222);
    check("wr20b_thru", 16'h2222);
    step(1'b0, 1'b1, 16'h0020, 16'h0000);
    check("rd20", 16'h2222);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 16'h0020, 16'h0000);
      check("hold20", 16'h2222);
    end

    step(1'b0, 1'b0, 16'h0030, 16'h7777);
    check("wr30_thru", 16'h7777);
    step(1'b1, 1'b0, 16'h0030, 16'hDEAD);
    check("midrst_out", 16'h0000);
    step(1'b0, 1'b1, 16'h0030, 16'h0000);
    check("rd30_after_rst", 16'h7777);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
